// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between NUM_REQ requesters (8N1 + even parity).
// Optional parity bit is built in when UART_TX_PARITY_EN is defined; otherwise frames are 10 bits.
module uart_tx_arbiter #(
  parameter int CLK_FREQ  = 125_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int NUM_REQ   = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  input  logic [8*NUM_REQ-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]     REQ_READY,
  output logic                   TXD,
  output logic                   BUSY,
  output logic [2:0]             GRANT_ID,
  output logic                   TX_DONE,
  output logic [2:0]             DBG_STATE
);
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

`ifdef UART_TX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  state_t            state_q, state_n;
  logic [BAUD_W-1:0] baud_q, baud_n;
  logic [2:0]        bit_q, bit_n;
  logic [2:0]        rr_q, rr_n;
  logic [2:0]        gnt_q, gnt_n;
  logic [7:0]        data_q, data_n;
  logic              txd_q, txd_n;
  logic              bit_end;
  logic              found;
  logic [2:0]        win;
  logic [2:0]        idx;
  logic [7:0]        valid8;
  logic [7:0]        win_data;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign BUSY      = (state_q != IDLE);
  assign TX_DONE   = (state_q == STOP) && bit_end;
  assign TXD       = txd_q;
  assign GRANT_ID  = gnt_q;
  assign DBG_STATE = state_q;

  // Circular scan from rr_q: the first pending requester wins.
  always_comb begin
    valid8 = '0;
    valid8[NUM_REQ-1:0] = REQ_VALID;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    win_data = '0;
    REQ_READY = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = 3'((int'(rr_q) + i) % NUM_REQ);
      if (!found && valid8[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 3'(i)) win_data = REQ_DATA[8*i +: 8];
      REQ_READY[i] = (state_q == IDLE) && !RST && found && (win == 3'(i));
    end
  end

  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    rr_n    = rr_q;
    gnt_n   = gnt_q;
    data_n  = data_q;
    if (state_q != IDLE) baud_n = bit_end ? '0 : baud_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_n = START;
          baud_n  = '0;
          bit_n   = '0;
          data_n  = win_data;
          gnt_n   = win;
          rr_n    = (win == 3'(NUM_REQ - 1)) ? 3'd0 : win + 3'd1;
        end
      end
      START:  if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) state_n = AFTER_DATA;
          else               bit_n   = bit_q + 3'd1;
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // TXD is registered, so its next value follows the next state.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = data_n[bit_n];
      PARITY:  txd_n = ^data_n;
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      rr_q    <= rr_n;
      gnt_q   <= gnt_n;
      data_q  <= data_n;
      txd_q   <= txd_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle timing model, table vectors, frame scoreboard.
// Frame length follows UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_arbiter;
  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int NUM_REQ   = 4;
  localparam int BC        = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * BC;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        txd, busy, tx_done;
  logic [2:0]  grant_id, dbg_state;

  // scoreboard item: {parity, id[2:0], data[7:0]}
  logic [11:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;
  int m_wait = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int last_done_cyc = 0;
  logic mon_en = 1'b1;

  uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .NUM_REQ(NUM_REQ)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_READY(req_ready), .TXD(txd), .BUSY(busy), .GRANT_ID(grant_id),
    .TX_DONE(tx_done), .DBG_STATE(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: checks flags against the timing model at negedge, returns the accept vector.
  task automatic cycle(output logic [3:0] acc);
    logic [3:0] exp_vec, act_vec, oh;
    @(negedge clk);
    acc = req_valid & req_ready;
    exp_vec = {m_wait != 0, m_wait == 1, (m_wait == 0) && (req_valid != 0), 1'b1};
    act_vec = {busy, tx_done, req_ready != 0, (m_wait == 0) ? txd : 1'b1};
    check("cycle_flags", act_vec, exp_vec);
    if (acc != 0) begin
      last_acc_cyc = cyc;
      if (exp_q.size() != 0) begin
        oh = 4'b0001 << exp_q[0][10:8];
        check("accept_onehot", req_ready, oh);
      end
    end
    if (tx_done) last_done_cyc = cyc;
    @(posedge clk); #1;
    cyc++;
    if (acc != 0) m_wait = FRAME;
    else if (m_wait != 0) m_wait--;
  endtask

  task automatic run_until_accept(output logic [3:0] acc);
    int n;
    acc = '0;
    n = 0;
    while (acc == 0 && n < 3 * FRAME) begin
      cycle(acc);
      n++;
    end
    check("accept_timeout", acc != 0, 1'b1);
  endtask

  task automatic run_until_idle();
    logic [3:0] a;
    int n;
    n = 0;
    while (m_wait != 0 && n < 2 * FRAME) begin
      cycle(a);
      n++;
    end
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [7:0] d, input logic par);
    exp_q.push_back({par, id, d});
  endtask

  // Asynchronous reset with valid held high: ready must stay low while reset is active.
  task automatic do_reset();
    req_valid = 4'hF;
    rst = 1'b1;
    #2;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", req_ready, 4'h0);
    check("rst_gnt", grant_id, 3'd0);
    check("rst_done", tx_done, 1'b0);
    req_valid = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_wait = 0;
  endtask

  // Frame monitor: pops the scoreboard on each start bit and checks every bit period.
  initial begin : monitor
    logic [11:0] e;
    logic [10:0] fr;
    logic exp_bit;
    int bad;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && txd === 1'b0) begin
        check("frame_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("start_gid", grant_id, e[10:8]);
          fr = '0;
          fr[8:1] = e[7:0];
          if (FB == 11) begin
            fr[9]  = e[11];
            fr[10] = 1'b1;
          end else begin
            fr[9] = 1'b1;
          end
          for (int b = 0; b < FB; b++) begin
            exp_bit = fr[0];
            fr = fr >> 1;
            bad = 0;
            for (int c = 0; c < BC; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (txd !== exp_bit) bad++;
            end
            check($sformatf("frame_bit%0d", b), bad, 0);
          end
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [2:0]  exp_gnt;
    logic [7:0]  exp_byte;
    logic        exp_par;
  } vec_t;

  initial begin : main
    vec_t tbl[8];
    logic [3:0] acc;
    int prev;

    #2;
    do_reset();

    // All four held valid: round-robin 0,1,2,3,0 with a single idle cycle between frames.
    req_data = 32'hE7_81_5A_3C;
    push_exp(3'd0, 8'h3C, ^8'h3C);
    push_exp(3'd1, 8'h5A, ^8'h5A);
    push_exp(3'd2, 8'h81, ^8'h81);
    push_exp(3'd3, 8'hE7, ^8'hE7);
    push_exp(3'd0, 8'h3C, ^8'h3C);
    req_valid = 4'hF;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      run_until_accept(acc);
      if (k > 0) check("frame_gap", last_acc_cyc - prev, FRAME + 1);
      prev = last_acc_cyc;
    end
    req_valid = '0;
    run_until_idle();
    do_reset();

    // Table vectors; rotation expectations assume rr_ptr starts at 0 here.
    tbl[0] = '{4'b0001, 32'hAAAA_AA41, 3'd0, 8'h41, 1'b0};
    tbl[1] = '{4'b0100, 32'h0007_0000, 3'd2, 8'h07, 1'b1};
    tbl[2] = '{4'b1010, 32'hC300_1100, 3'd3, 8'hC3, 1'b0};
    tbl[3] = '{4'b0010, 32'h0000_FF00, 3'd1, 8'hFF, 1'b0};
    tbl[4] = '{4'b1001, 32'h8000_0001, 3'd3, 8'h80, 1'b1};
    tbl[5] = '{4'b1111, 32'h1234_5600, 3'd0, 8'h00, 1'b0};
    tbl[6] = '{4'b0001, 32'h0000_0055, 3'd0, 8'h55, 1'b0};
    tbl[7] = '{4'b1100, 32'h00FE_0000, 3'd2, 8'hFE, 1'b1};
    for (int v = 0; v < 8; v++) begin
      req_data  = tbl[v].data;
      req_valid = tbl[v].valid;
      push_exp(tbl[v].exp_gnt, tbl[v].exp_byte, tbl[v].exp_par);
      run_until_accept(acc);
      req_valid = '0;
      check($sformatf("tbl%0d_gnt", v), grant_id, tbl[v].exp_gnt);
      run_until_idle();
      check($sformatf("tbl%0d_done_latency", v), last_done_cyc - last_acc_cyc, FRAME);
    end

    // Request raised while busy waits until the idle cycle right after TX_DONE.
    req_data[7:0] = 8'h3A;
    req_valid = 4'b0001;
    push_exp(3'd0, 8'h3A, ^8'h3A);
    run_until_accept(acc);
    req_valid = '0;
    repeat ($urandom_range(5, 60)) cycle(acc);
    req_data[15:8] = 8'h96;
    req_valid = 4'b0010;
    push_exp(3'd1, 8'h96, ^8'h96);
    run_until_accept(acc);
    req_valid = '0;
    check("busy_req_accept_cycle", last_acc_cyc, last_done_cyc + 1);
    run_until_idle();

    // Reset during data bit 4 aborts the frame; next grant restarts at requester 0.
    mon_en = 1'b0;
    req_data = 32'h0000_00A5;
    req_valid = 4'b0001;
    run_until_accept(acc);
    req_valid = '0;
    repeat (55) cycle(acc);
    check("pre_rst_bit4", txd, 1'b0);
    req_valid = 4'hF;
    #2;
    rst = 1'b1;
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", req_ready, 4'h0);
    check("abort_state", dbg_state, 3'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_wait = 0;
    mon_en = 1'b1;
    push_exp(3'd0, 8'hA5, ^8'hA5);
    run_until_accept(acc);
    req_valid = '0;
    check("post_rst_grant", acc, 4'b0001);
    run_until_idle();
    repeat (3) cycle(acc);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
